demux1_2_fifo: RTL and testbench

- 1-to-2 datapath demultiplexer for the 16-bit CPU datapath. It is the fan-out counterpart to the 2:1 operand select.
- Accepts one word stream with a per-word destination select, and steers each word into one of two per-destination FIFOs.
- Each output is drained independently with valid/ready handshakes.
- Used to split one result bus between two consumers, e.g. register-file write-back and memory store path, without losing words when one consumer stalls.

---
 rtl/demux1_2_fifo.sv | 162 ++++++++++++++++
 tb/tb_demux1_2_fifo.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/demux1_2_fifo.sv
// demux1_2_fifo: steers one word stream into two independent FIFOs.
// Each word goes to out0 or out1 according to in_select. Each output
// drains with its own valid/ready handshake. When the selected FIFO is
// full the input stalls; there is no bypass into the other FIFO.

// Single-clock FIFO used for each destination. Storage uses registers,
// and the head entry is read combinationally.
module demux1_2_fifo_buf #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop_ready,
  output logic [WIDTH-1:0]         rdata,
  output logic                     valid,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wptr_r;
  logic [AW-1:0]    rptr_r;
  logic [CW-1:0]    count_r;
  logic             pop_s;

  // A pop happens only when the FIFO holds a word and the consumer takes it
  always_comb begin
    pop_s = 1'b0;
    if (count_r != {CW{1'b0}}) begin
      pop_s = pop_ready;
    end else begin
      pop_s = 1'b0;
    end
  end

  // Write a pushed word into storage; all entries clear on reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {WIDTH{1'b0}};
      end
    end else if (push) begin
      mem_r[wptr_r] <= wdata;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_r <= {AW{1'b0}};
      rptr_r <= {AW{1'b0}};
    end else begin
      if (push) begin
        wptr_r <= wptr_r + AW'(1);
      end
      if (pop_s) begin
        rptr_r <= rptr_r + AW'(1);
      end
    end
  end

  // Occupancy tracks push/pop and tells full from empty
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r <= {CW{1'b0}};
    end else begin
      case ({push, pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  assign rdata = mem_r[rptr_r];
  assign valid = (count_r != {CW{1'b0}});
  assign count = count_r;

endmodule

// Top level: input routing plus two destination FIFOs
module demux1_2_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [WIDTH-1:0]         in_data,
  input  logic                     in_select,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [WIDTH-1:0]         out0_data,
  output logic                     out0_valid,
  input  logic                     out0_ready,
  output logic [WIDTH-1:0]         out1_data,
  output logic                     out1_valid,
  input  logic                     out1_ready,
  output logic [$clog2(DEPTH):0]   count0,
  output logic [$clog2(DEPTH):0]   count1
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic ready_s;
  logic push0_s;
  logic push1_s;

  // Readiness looks only at the selected FIFO's registered occupancy,
  // so a same-cycle pop never opens the input (no ready-to-ready path)
  always_comb begin
    ready_s = 1'b0;
    if (in_select) begin
      ready_s = (count1 != CW'(DEPTH));
    end else begin
      ready_s = (count0 != CW'(DEPTH));
    end
  end

  // Route an accepted word to exactly one FIFO; in_valid low masks any
  // unknown value on in_select or in_data
  always_comb begin
    push0_s = 1'b0;
    push1_s = 1'b0;
    if (in_valid && ready_s) begin
      push0_s = ~in_select;
      push1_s = in_select;
    end else begin
      push0_s = 1'b0;
      push1_s = 1'b0;
    end
  end

  assign in_ready = ready_s;

  demux1_2_fifo_buf #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo0 (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push0_s),
    .wdata     (in_data),
    .pop_ready (out0_ready),
    .rdata     (out0_data),
    .valid     (out0_valid),
    .count     (count0)
  );

  demux1_2_fifo_buf #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push1_s),
    .wdata     (in_data),
    .pop_ready (out1_ready),
    .rdata     (out1_data),
    .valid     (out1_valid),
    .count     (count1)
  );

endmodule

// File: tb/tb_demux1_2_fifo.sv
// Directed self-checking bench for demux1_2_fifo (WIDTH=16, DEPTH=2).
// Inputs change 1 ns after each rising edge, and outputs are sampled at
// that same point.
module tb_demux1_2_fifo;

  logic        clk;
  logic        rst_n;
  logic [15:0] in_data;
  logic        in_select;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] out0_data;
  logic        out0_valid;
  logic        out0_ready;
  logic [15:0] out1_data;
  logic        out1_valid;
  logic        out1_ready;
  logic [1:0]  count0;
  logic [1:0]  count1;

  int checks = 0;
  int errors = 0;

  demux1_2_fifo #(.WIDTH(16), .DEPTH(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_data    (in_data),
    .in_select  (in_select),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out0_data  (out0_data),
    .out0_valid (out0_valid),
    .out0_ready (out0_ready),
    .out1_data  (out1_data),
    .out1_valid (out1_valid),
    .out1_ready (out1_ready),
    .count0     (count0),
    .count1     (count1)
  );

  // 10 ns clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n      = 1'b0;
    in_data    = 16'h0000;
    in_select  = 1'b0;
    in_valid   = 1'b0;
    out0_ready = 1'b0;
    out1_ready = 1'b0;

    // 1. reset then idle
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("rst_count0", count0, 2'd0);
    chk("rst_count1", count1, 2'd0);
    chk("rst_valid0", out0_valid, 1'b0);
    chk("rst_valid1", out1_valid, 1'b0);
    chk("rst_data0", out0_data, 16'h0000);
    chk("rst_data1", out1_data, 16'h0000);
    chk("rst_in_ready", in_ready, 1'b1);

    // unknown data/select with in_valid low changes nothing
    in_data   = 16'hxxxx;
    in_select = 1'bx;
    step();
    chk("x_count0", count0, 2'd0);
    chk("x_count1", count1, 2'd0);
    in_select = 1'b0;

    // 2. basic route
    in_valid = 1'b1; in_select = 1'b0; in_data = 16'hA5A5;
    step();
    chk("route_data0", out0_data, 16'hA5A5);
    chk("route_valid0", out0_valid, 1'b1);
    chk("route_valid1_idle", out1_valid, 1'b0);
    in_select = 1'b1; in_data = 16'h5A5A;
    step();
    in_valid = 1'b0;
    chk("route_data1", out1_data, 16'h5A5A);
    chk("route_valid1", out1_valid, 1'b1);
    chk("route_count0", count0, 2'd1);
    chk("route_count1", count1, 2'd1);

    // drain both in the same cycle
    out0_ready = 1'b1; out1_ready = 1'b1;
    step();
    out0_ready = 1'b0; out1_ready = 1'b0;
    chk("drain_count0", count0, 2'd0);
    chk("drain_count1", count1, 2'd0);

    // 3. fill and backpressure
    in_valid = 1'b1; in_select = 1'b0; in_data = 16'h0001;
    step();
    in_data = 16'h0002;
    step();
    in_valid = 1'b0;
    chk("fill_count0", count0, 2'd2);
    chk("fill_head0", out0_data, 16'h0001);
    chk("full_ready_sel0", in_ready, 1'b0);
    in_select = 1'b1;
    #1;
    chk("full_ready_sel1", in_ready, 1'b1);
    // full while popping: input still refused this cycle
    in_select = 1'b0; in_valid = 1'b1; in_data = 16'h0003; out0_ready = 1'b1;
    #1;
    chk("full_pop_ready", in_ready, 1'b0);
    step();
    in_valid = 1'b0; out0_ready = 1'b0;
    chk("pop_count0", count0, 2'd1);
    chk("pop_head0", out0_data, 16'h0002);
    chk("pop_ready_back", in_ready, 1'b1);
    out0_ready = 1'b1;
    step();
    chk("empty_count0", count0, 2'd0);

    // 4. streaming push/pop across pointer wrap
    in_valid = 1'b1; in_select = 1'b0;
    for (int i = 0; i < 8; i++) begin
      in_data = 16'h0010 + 16'(i);
      step();
      chk("stream_data0", out0_data, 16'h0010 + 16'(i));
      chk("stream_count0", count0, 2'd1);
    end
    in_valid = 1'b0;
    step();
    out0_ready = 1'b0;
    chk("stream_end_count0", count0, 2'd0);

    // 5. head-of-line blocking on out1
    in_valid = 1'b1; in_select = 1'b1; in_data = 16'h0101;
    step();
    in_data = 16'h0102;
    step();
    chk("hol_count1", count1, 2'd2);
    in_data = 16'h0103;
    #1;
    chk("hol_in_ready", in_ready, 1'b0);
    step();
    chk("hol_hold_count1", count1, 2'd2);
    chk("hol_count0", count0, 2'd0);
    chk("hol_valid0", out0_valid, 1'b0);
    chk("hol_head1", out1_data, 16'h0101);
    out1_ready = 1'b1;
    step();
    out1_ready = 1'b0;
    chk("hol_pop_count1", count1, 2'd1);
    chk("hol_pop_head1", out1_data, 16'h0102);
    step();
    in_valid = 1'b0;
    chk("hol_accept_count1", count1, 2'd2);
    out1_ready = 1'b1;
    step();
    chk("hol_order_head1", out1_data, 16'h0103);
    step();
    out1_ready = 1'b0;
    chk("hol_empty_count1", count1, 2'd0);

    // 6. asynchronous reset mid-operation
    in_valid = 1'b1; in_select = 1'b0; in_data = 16'h0A01;
    step();
    in_data = 16'h0A02;
    step();
    in_select = 1'b1; in_data = 16'h0B01;
    step();
    in_valid = 1'b0;
    chk("pre_rst_count0", count0, 2'd2);
    chk("pre_rst_count1", count1, 2'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_count0", count0, 2'd0);
    chk("mid_rst_count1", count1, 2'd0);
    chk("mid_rst_valid0", out0_valid, 1'b0);
    chk("mid_rst_valid1", out1_valid, 1'b0);
    chk("mid_rst_data1", out1_data, 16'h0000);
    @(posedge clk);
    #1 rst_n = 1'b1;
    in_valid = 1'b1; in_select = 1'b1; in_data = 16'hBEEF;
    step();
    in_valid = 1'b0;
    chk("post_rst_data1", out1_data, 16'hBEEF);
    chk("post_rst_count1", count1, 2'd1);
    chk("post_rst_count0", count0, 2'd0);
    chk("post_rst_valid0", out0_valid, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
